// File: rtl/stream_hasher.sv
// stream_hasher: absorbs a byte stream round-robin into NUM_CHAINS hash chains, XOR-folds them and emits a rotated 32-bit digest.
module hash_round (
  input  logic [31:0] state_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] state_o
);
  logic [31:0] mixed;
  assign mixed   = state_i ^ {24'h0, byte_i};
  assign state_o = {mixed[26:0], mixed[31:27]} + 32'h9E3779B9;
endmodule

module rotator #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     dir_i,
  input  logic [$clog2(WIDTH)-1:0] dist_i,
  output logic [WIDTH-1:0]         data_o
);
  logic [2*WIDTH-1:0] sl, sr;
  assign sl     = {data_i, data_i} << dist_i;
  assign sr     = {data_i, data_i} >> dist_i;
  assign data_o = dir_i ? sl[2*WIDTH-1:WIDTH] : sr[WIDTH-1:0];
endmodule

module stream_hasher #(
  parameter int  NUM_CHAINS = 2,
  parameter int  MAX_LEN    = 255,
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  input  logic             in_empty,
  output logic             hash_valid,
  input  logic             hash_ready,
  output logic [31:0]      hash,
  output logic [LEN_W-1:0] hash_len,
  output logic             overflow
);
  localparam int IDX_W = NUM_CHAINS > 1 ? $clog2(NUM_CHAINS) : 1;
  typedef enum logic [1:0] {IDLE, ABSORB, FINAL, DONE} state_t;
  state_t           state_q, state_d;
  logic [31:0]      chain_q [NUM_CHAINS];
  logic [31:0]      round_out, fold, rot_out, hash_q;
  logic [IDX_W-1:0] idx_q;
  logic [LEN_W-1:0] cnt_q;
  logic             hash_valid_q, overflow_q;
  logic             accept, empty_msg, absorb, release_hash;
  assign in_ready     = state_q == IDLE || state_q == ABSORB;
  assign accept       = in_valid && in_ready;
  assign empty_msg    = state_q == IDLE && in_empty && in_last;
  assign absorb       = accept && !empty_msg && cnt_q < LEN_W'(MAX_LEN);
  assign release_hash = hash_valid_q && hash_ready;
  hash_round u_round (
    .state_i(chain_q[idx_q]),
    .byte_i (in_byte),
    .state_o(round_out)
  );
  always_comb begin
    fold = '0;
    for (int k = 0; k < NUM_CHAINS; k++) fold = fold ^ chain_q[k];
  end
  rotator #(.WIDTH(32)) u_rot (
    .data_i(fold),
    .dir_i (cnt_q != '0),
    .dist_i(fold[4:0]),
    .data_o(rot_out)
  );
  always_comb begin
    state_d = state_q == FINAL ? DONE :
              state_q == DONE  ? (release_hash ? IDLE : DONE) :
              accept           ? (in_last ? FINAL : ABSORB) : state_q;
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
    if (reset || release_hash) begin
      // 0x55555555 rotated left by k simply alternates with the parity of k
      for (int k = 0; k < NUM_CHAINS; k++) chain_q[k] <= (k % 2 == 1) ? 32'hAAAAAAAA : 32'h55555555;
      idx_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else if (absorb) begin
      chain_q[idx_q] <= round_out;
      idx_q          <= idx_q == IDX_W'(NUM_CHAINS - 1) ? '0 : idx_q + IDX_W'(1);
      cnt_q          <= cnt_q + LEN_W'(1);
    end else if (accept && !empty_msg) begin
      overflow_q <= 1'b1;
    end
    if (reset) begin
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
    end else if (state_q == FINAL) begin
      hash_q       <= rot_out;
      hash_valid_q <= 1'b1;
    end else if (release_hash) begin
      hash_valid_q <= 1'b0;
    end
  end
  assign hash_valid = hash_valid_q;
  assign hash       = hash_q;
  assign hash_len   = cnt_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_stream_hasher.sv
// tb_stream_hasher: three parameterisations driven in lockstep, checked against a golden model of the chained hash.
module tb_stream_hasher;
  localparam int NC [3] = '{2, 3, 1};
  localparam int ML [3] = '{255, 4, 6};

  typedef struct packed {
    logic [3:0]      n;
    logic [7:0][7:0] b;
    logic            empty;
    logic            gaps;
    logic [3:0]      hold;
    logic [2:0][7:0] len;
    logic [2:0]      ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_last, in_empty, hash_ready;
  logic [7:0]  in_byte;
  logic        rdy_w [3];
  logic        hv_w [3];
  logic        ov_w [3];
  logic [31:0] hash_w [3];
  logic [7:0]  len_a;
  logic [2:0]  len_b, len_c;
  logic [7:0]  lv [3];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  vec_t        tbl [7];

  assign lv[0] = len_a;
  assign lv[1] = {5'b0, len_b};
  assign lv[2] = {5'b0, len_c};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_hasher #(.NUM_CHAINS(2), .MAX_LEN(255)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w[0]), .in_byte(in_byte),
    .in_last(in_last), .in_empty(in_empty), .hash_valid(hv_w[0]), .hash_ready(hash_ready),
    .hash(hash_w[0]), .hash_len(len_a), .overflow(ov_w[0]));
  stream_hasher #(.NUM_CHAINS(3), .MAX_LEN(4)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w[1]), .in_byte(in_byte),
    .in_last(in_last), .in_empty(in_empty), .hash_valid(hv_w[1]), .hash_ready(hash_ready),
    .hash(hash_w[1]), .hash_len(len_b), .overflow(ov_w[1]));
  stream_hasher #(.NUM_CHAINS(1), .MAX_LEN(6)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w[2]), .in_byte(in_byte),
    .in_last(in_last), .in_empty(in_empty), .hash_valid(hv_w[2]), .hash_ready(hash_ready),
    .hash(hash_w[2]), .hash_len(len_c), .overflow(ov_w[2]));

  function automatic logic [31:0] m_round(input logic [31:0] s, input logic [7:0] b);
    logic [31:0] x;
    x = s ^ {24'h0, b};
    return {x[26:0], x[31:27]} + 32'h9E3779B9;
  endfunction

  function automatic logic [31:0] m_rot(input logic [31:0] v, input logic left, input int d);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < d; i++) r = left ? {r[30:0], r[31]} : {r[0], r[31:1]};
    return r;
  endfunction

  function automatic logic [31:0] m_digest(input logic [7:0][7:0] b, input int n, input int nc, input int ml);
    logic [31:0] ch [8];
    logic [31:0] f;
    int used;
    used = n < ml ? n : ml;
    for (int k = 0; k < nc; k++) ch[k] = m_rot(32'h55555555, 1'b1, k);
    for (int i = 0; i < used; i++) ch[i % nc] = m_round(ch[i % nc], b[i]);
    f = '0;
    for (int k = 0; k < nc; k++) f = f ^ ch[k];
    return m_rot(f, used != 0, int'(f[4:0]));
  endfunction

  function automatic vec_t mk(input int n, input logic [63:0] b, input logic e, input logic g, input int h,
                              input int la, input int lb, input int lc, input logic oa, input logic ob, input logic oc);
    vec_t v;
    v.n = 4'(n); v.b = b; v.empty = e; v.gaps = g; v.hold = 4'(h);
    v.len[0] = 8'(la); v.len[1] = 8'(lb); v.len[2] = 8'(lc);
    v.ov[0] = oa; v.ov[1] = ob; v.ov[2] = oc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_ready_%0d", tag, d), 32'(rdy_w[d]), 32'd1);
      chk($sformatf("%s_hvalid_%0d", tag, d), 32'(hv_w[d]), 32'd0);
      chk($sformatf("%s_hash_%0d", tag, d), hash_w[d], 32'd0);
      chk($sformatf("%s_len_%0d", tag, d), 32'(lv[d]), 32'd0);
      chk($sformatf("%s_ovf_%0d", tag, d), 32'(ov_w[d]), 32'd0);
    end
  endtask

  // call and return #1 after a rising edge
  task automatic drive_beat(input logic [7:0] b, input logic last, input logic emp);
    int t;
    t = 0;
    in_valid = 1'b1; in_byte = b; in_last = last; in_empty = emp;
    @(negedge clk);
    while (!rdy_w[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("accept_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int nb;
    nb = (v.n == 0) ? 1 : int'(v.n);
    for (int i = 0; i < nb; i++) begin
      drive_beat(v.b[i], i == nb - 1, v.empty);
      if (v.gaps && i != nb - 1) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    chk($sformatf("v%0d_final_hvalid", vi), 32'(hv_w[0]), 32'd0);
    chk($sformatf("v%0d_final_ready", vi), 32'(rdy_w[0]), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_latency_hvalid", vi), 32'(hv_w[0]), 32'd1);
    in_valid = 1'b1; in_byte = 8'h77;
    for (int h = 0; h < int'(v.hold); h++) begin
      @(negedge clk);
      chk($sformatf("v%0d_hold%0d_hvalid", vi, h), 32'(hv_w[0]), 32'd1);
      chk($sformatf("v%0d_hold%0d_ready", vi, h), 32'(rdy_w[0]), 32'd0);
      chk($sformatf("v%0d_hold%0d_hash", vi, h), hash_w[0], m_digest(v.b, int'(v.n), NC[0], ML[0]));
    end
    hash_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("v%0d_hash_%0d", vi, d), hash_w[d], m_digest(v.b, int'(v.n), NC[d], ML[d]));
      chk($sformatf("v%0d_len_%0d", vi, d), 32'(lv[d]), 32'(v.len[d]));
      chk($sformatf("v%0d_ovf_%0d", vi, d), 32'(ov_w[d]), 32'(v.ov[d]));
      chk($sformatf("v%0d_done_ready_%0d", vi, d), 32'(rdy_w[d]), 32'd0);
    end
    @(posedge clk); #1;
    hash_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_cleared_hvalid", vi), 32'(hv_w[0]), 32'd0);
    chk($sformatf("v%0d_cleared_ready", vi), 32'(rdy_w[0]), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(0, 64'h0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(8, 64'h0807060504030201, 1'b0, 1'b0, 0, 8, 4, 6, 1'b0, 1'b1, 1'b1);
    tbl[2] = mk(8, 64'h0807060504030201, 1'b0, 1'b1, 5, 8, 4, 6, 1'b0, 1'b1, 1'b1);
    tbl[3] = mk(6, 64'h0000605040302010, 1'b0, 1'b0, 1, 6, 4, 6, 1'b0, 1'b1, 1'b0);
    tbl[4] = mk(1, 64'h00000000000000FF, 1'b0, 1'b0, 0, 1, 1, 1, 1'b0, 1'b0, 1'b0);
    tbl[5] = mk(4, 64'h00000000EFBEADDE, 1'b0, 1'b0, 2, 4, 4, 4, 1'b0, 1'b0, 1'b0);
    tbl[6] = mk(3, 64'h0000000000332211, 1'b1, 1'b1, 0, 3, 3, 3, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0; in_empty = 1'b0; hash_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_idle($sformatf("rst%0d", c));
    end
    @(posedge clk); #1;
    for (int vi = 0; vi < 7; vi++) run_vec(vi, tbl[vi]);
    drive_beat(8'h01, 1'b0, 1'b0);
    drive_beat(8'h02, 1'b0, 1'b0);
    drive_beat(8'h03, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle("midmsg");
    @(posedge clk); #1;
    run_vec(7, mk(2, 64'h000000000000BBAA, 1'b0, 1'b0, 0, 2, 2, 2, 1'b0, 1'b0, 1'b0));
    drive_beat(8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("middone_hvalid", 32'(hv_w[0]), 32'd1);
    hash_ready = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; hash_ready = 1'b0;
    @(negedge clk);
    chk_idle("middone");
    @(posedge clk); #1;
    run_vec(8, mk(2, 64'h000000000000BBAA, 1'b0, 1'b1, 1, 2, 2, 2, 1'b0, 1'b0, 1'b0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_hasher.md
Name: stream_hasher

Overview:
- Sequential, parametrised successor to the fixed 8-byte combinational hasher.
- Absorbs a variable-length byte stream one byte per cycle over a valid/ready handshake.
- Spreads bytes round-robin over NUM_CHAINS hash chains, then XOR-folds the chains and rotates the result.
- Presents a 32-bit digest on a held output handshake. Reuses the existing hash_round (32-bit state, 8-bit byte) and rotator (WIDTH=32) modules.

Parameters:
- NUM_CHAINS, 2, number of interleaved hash chains (1..8); byte i feeds chain i mod NUM_CHAINS.
- MAX_LEN, 255, maximum absorbed bytes per message (>=1).
- LEN_W, derived localparam = $clog2(MAX_LEN+1), width of length fields.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_byte/in_last/in_empty valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_byte  in  8  message byte.
- in_last  in  1  final beat of message.
- in_empty  in  1  qualifies in_last: message has zero bytes, in_byte ignored; meaningful only with in_last=1 on first beat.
- hash_valid  out  1  digest available.
- hash_ready  in  1  consumer takes digest.
- hash  out  32  digest.
- hash_len  out  LEN_W  absorbed byte count, saturates at MAX_LEN.
- overflow  out  1  message exceeded MAX_LEN bytes.

Behaviour:
- Clock/reset: one clock domain, clk; reset is synchronous and active-high.
- Seeds: chain k seed = 32'h55555555 rotated left by k (k=0: 0x55555555, k=1: 0xAAAAAAAA).
- Reset values: state IDLE, in_ready=1, hash_valid=0, hash=0, hash_len=0, overflow=0, byte counter=0, every chain = its seed.
- Beat accepted when in_valid && in_ready.
- States:
  - IDLE: in_ready=1; accepted beat moves to ABSORB, or straight to FINAL if in_last.
  - ABSORB: in_ready=1; accepted non-empty beat with index i < MAX_LEN sets chain[i mod NUM_CHAINS] = hash_round(in_byte, chain) and increments the counter. Index i >= MAX_LEN: beat consumed, not absorbed, overflow latched 1. Accepted in_last goes to FINAL.
  - FINAL: in_ready=0. final_state = XOR of all chains; dir = (hash_len != 0); distance = final_state[4:0]. Registers rotator output into hash, sets hash_valid=1, goes to DONE.
  - DONE: in_ready=0; hash, hash_len and overflow held stable. When hash_valid && hash_ready, clears hash_valid, reseeds the chains, clears counter and overflow, goes to IDLE.
- A single hash_round instance is shared, with the chain state muxed by index. Absorption is one byte per cycle with no bubbles.
- Latency: last beat accepted in cycle N -> hash_valid=1 in cycle N+2. Next message's first beat is accepted no earlier than the cycle after the hash handshake.
- in_empty on a non-first beat is ignored (treated as a normal byte).
- in_empty with in_last on the first beat: no byte absorbed, hash_len=0, dir=0.
- Counter saturates at MAX_LEN; no wrap.
- in_valid gaps: chains and counter hold.
- Reset mid-message or mid-DONE: reset wins over every other event. All state returns to reset values next cycle and the pending digest is discarded.
- Simultaneous hash_ready and in_valid in DONE: digest consumed; the input beat is not accepted (in_ready=0 that cycle).

Test Plan:
- Reset held 3 cycles then released, in_valid=0 -> in_ready=1, hash_valid=0, hash=0, overflow=0 indefinitely.
- Empty message: single beat in_last=1, in_empty=1 at cycle N -> hash_valid=1 at N+2; hash = rotator(0xFFFFFFFF, dir=0, distance=31); hash_len=0.
- Bytes 0x01..0x08 back-to-back, last at beat 8, NUM_CHAINS=2 -> digest equals golden model of this spec (even bytes into chain 0, odd into chain 1, XOR fold, dir=1, rotate by [4:0]); hash_len=8; latency 2.
- Same 8 bytes with in_valid deasserted every other cycle and hash_ready held low 5 cycles -> identical digest; hash_valid held, hash stable, in_ready=0 throughout DONE; cleared one cycle after hash_ready.
- MAX_LEN=4, 6-byte message -> hash_len=4, overflow=1, digest equals golden model over first 4 bytes only.
- Reset asserted after 3 bytes, then fresh 2-byte message 0xAA,0xBB -> digest equals golden model of {0xAA,0xBB} only. Repeat with NUM_CHAINS=1 and NUM_CHAINS=3.
